// File: rtl/tbl_access_master.sv
// Initiator for the forwarding-table req/ack handshake: turns one software command
// into a single read or write request pulse and returns one response (data or timeout).
module tbl_access_master #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int TBL_ADDR_WIDTH     = 5,
  parameter int TIMEOUT_CYCLES     = 16
) (
  input  logic                          AXI_ACLK,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [TBL_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                          rsp_valid,
  output logic                          rsp_error,
  output logic [C_S_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic                          busy,
  output logic [31:0]                   timeout_count,
  input  logic                          cnt_clear,
  output logic                          tbl_rd_req,
  output logic                          tbl_wr_req,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_rd_addr,
  output logic [TBL_ADDR_WIDTH-1:0]     tbl_wr_addr,
  output logic [C_S_AXI_DATA_WIDTH-1:0] tbl_wr_data,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] tbl_rd_data,
  input  logic                          tbl_rd_ack,
  input  logic                          tbl_wr_ack
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       op_write;
  logic [7:0] wait_cnt;
  logic       accept;
  logic       ack_match;
  logic       timeout_hit;

  // Only the ack that matches the outstanding operation ends WAIT; an ack wins over timeout.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    ack_match   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: state_next = WAIT;
      WAIT: begin
        ack_match = op_write ? tbl_wr_ack : tbl_rd_ack;
        if (ack_match) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_rdata     <= '0;
      busy          <= 1'b0;
      timeout_count <= '0;
      tbl_rd_req    <= 1'b0;
      tbl_wr_req    <= 1'b0;
      tbl_rd_addr   <= '0;
      tbl_wr_addr   <= '0;
      tbl_wr_data   <= '0;
      op_write      <= 1'b0;
      wait_cnt      <= '0;
    end else begin
      tbl_rd_req <= 1'b0;
      tbl_wr_req <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_error  <= 1'b0;

      if (accept) begin
        op_write  <= cmd_write;
        cmd_ready <= 1'b0;
        busy      <= 1'b1;
        if (cmd_write) begin
          tbl_wr_addr <= cmd_addr;
          tbl_wr_data <= cmd_wdata;
          tbl_wr_req  <= 1'b1;
        end else begin
          tbl_rd_addr <= cmd_addr;
          tbl_rd_req  <= 1'b1;
        end
      end

      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 8'd1;

      if (ack_match) begin
        rsp_valid <= 1'b1;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
        if (!op_write) rsp_rdata <= tbl_rd_data;
      end

      if (timeout_hit) begin
        rsp_valid <= 1'b1;
        rsp_error <= 1'b1;
        rsp_rdata <= '0;
        cmd_ready <= 1'b1;
        busy      <= 1'b0;
      end

      // A software clear beats a coincident timeout increment.
      if (cnt_clear)
        timeout_count <= '0;
      else if (timeout_hit && (timeout_count != 32'hFFFF_FFFF))
        timeout_count <= timeout_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_tbl_access_master.sv
// Directed bench for tbl_access_master: a model table responder plus a response
// scoreboard that knows the cycle, error flag and data each response must carry.
module tb_tbl_access_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          AXI_ACLK;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid;
  logic          rsp_error;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [31:0]   timeout_count;
  logic          cnt_clear;
  logic          tbl_rd_req;
  logic          tbl_wr_req;
  logic [AW-1:0] tbl_rd_addr;
  logic [AW-1:0] tbl_wr_addr;
  logic [DW-1:0] tbl_wr_data;
  logic [DW-1:0] tbl_rd_data;
  logic          tbl_rd_ack;
  logic          tbl_wr_ack;

  tbl_access_master #(
    .C_S_AXI_DATA_WIDTH(DW),
    .TBL_ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .AXI_ACLK     (AXI_ACLK),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_error    (rsp_error),
    .rsp_rdata    (rsp_rdata),
    .busy         (busy),
    .timeout_count(timeout_count),
    .cnt_clear    (cnt_clear),
    .tbl_rd_req   (tbl_rd_req),
    .tbl_wr_req   (tbl_wr_req),
    .tbl_rd_addr  (tbl_rd_addr),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .tbl_rd_data  (tbl_rd_data),
    .tbl_rd_ack   (tbl_rd_ack),
    .tbl_wr_ack   (tbl_wr_ack)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            checks     = 0;
  int            errors     = 0;
  int            cycle      = 0;
  int            req_pulses = 0;
  int            rsp_pulses = 0;
  logic [DW-1:0] mem [32];
  bit            auto_en    = 1'b0;
  int            ack_delay  = 1;
  int            pend_cnt   = 0;
  bit            pend_wr    = 1'b0;
  logic [AW-1:0] pend_addr  = '0;
  int            sched_rd   = -1;
  int            sched_wr   = -1;

  initial AXI_ACLK = 1'b0;
  always #5 AXI_ACLK = ~AXI_ACLK;

  always @(posedge AXI_ACLK) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge AXI_ACLK);
    #1;
  endtask

  task automatic waitNeg(input int n);
    forever begin
      @(negedge AXI_ACLK);
      if (cycle >= n) break;
    end
  endtask

  task automatic expectRsp(input logic err, input logic [DW-1:0] rdata, input int cyc);
    exp_t e;
    e.err   = err;
    e.rdata = rdata;
    e.cyc   = cyc;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; returns the cycle in which the command was accepted.
  task automatic applyStimulus(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input bit hold, output int t_acc);
    bit got;
    got       = 1'b0;
    t_acc     = -1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge AXI_ACLK);
      if (cmd_ready === 1'b1) begin
        got   = 1'b1;
        t_acc = cycle;
      end
      nextCycle();
    end
    if (!hold) cmd_valid = 1'b0;
    if (!got) checkOutput("cmd_accept", 64'(got), 64'd1);
  endtask

  task automatic drainScoreboard(input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge AXI_ACLK);
      if (sb.size() == 0) break;
    end
    @(negedge AXI_ACLK);
    checkOutput("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_cmd_ready"},     64'(cmd_ready),     64'd1);
    checkOutput({pfx, "_rsp_valid"},     64'(rsp_valid),     64'd0);
    checkOutput({pfx, "_rsp_error"},     64'(rsp_error),     64'd0);
    checkOutput({pfx, "_busy"},          64'(busy),          64'd0);
    checkOutput({pfx, "_rd_req"},        64'(tbl_rd_req),    64'd0);
    checkOutput({pfx, "_wr_req"},        64'(tbl_wr_req),    64'd0);
    checkOutput({pfx, "_rsp_rdata"},     64'(rsp_rdata),     64'd0);
    checkOutput({pfx, "_timeout_count"}, 64'(timeout_count), 64'd0);
    checkOutput({pfx, "_rd_addr"},       64'(tbl_rd_addr),   64'd0);
    checkOutput({pfx, "_wr_addr"},       64'(tbl_wr_addr),   64'd0);
    checkOutput({pfx, "_wr_data"},       64'(tbl_wr_data),   64'd0);
  endtask

  // Model table: acks ack_delay cycles after a req when auto_en, plus scheduled raw acks.
  always @(posedge AXI_ACLK) begin
    #1;
    tbl_rd_ack = 1'b0;
    tbl_wr_ack = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        if (pend_wr) begin
          tbl_wr_ack = 1'b1;
        end else begin
          tbl_rd_ack  = 1'b1;
          tbl_rd_data = mem[pend_addr];
        end
      end
    end
    if (auto_en && tbl_wr_req === 1'b1) begin
      mem[tbl_wr_addr] = tbl_wr_data;
      pend_wr          = 1'b1;
      pend_cnt         = ack_delay;
    end
    if (auto_en && tbl_rd_req === 1'b1) begin
      pend_wr   = 1'b0;
      pend_addr = tbl_rd_addr;
      pend_cnt  = ack_delay;
    end
    if (cycle == sched_rd) begin
      tbl_rd_ack  = 1'b1;
      tbl_rd_data = 32'hDEAD_BEEF;
    end
    if (cycle == sched_wr) tbl_wr_ack = 1'b1;
  end

  // Response monitor: every rsp_valid must match the oldest expected response exactly.
  always @(negedge AXI_ACLK) begin
    exp_t e;
    if (tbl_rd_req === 1'b1 || tbl_wr_req === 1'b1) req_pulses++;
    if (tbl_rd_req === 1'b1 && tbl_wr_req === 1'b1)
      checkOutput("req_exclusive", 64'(tbl_rd_req & tbl_wr_req), 64'd0);
    if (rsp_valid === 1'b1) begin
      rsp_pulses++;
      if (sb.size() == 0) begin
        checkOutput("rsp_unexpected", 64'(rsp_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rsp_error", 64'(rsp_error), 64'(e.err));
        checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        checkOutput("rsp_cycle", 64'(cycle),     64'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: observed no completion expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    int t2;
    int tb2b [4];
    int base_req;
    int base_rsp;

    for (int i = 0; i < 32; i++) mem[i] = '0;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    cnt_clear   = 1'b0;
    tbl_rd_data = '0;
    tbl_rd_ack  = 1'b0;
    tbl_wr_ack  = 1'b0;

    repeat (3) nextCycle();
    @(negedge AXI_ACLK);
    checkResetState("rst");
    nextCycle();
    reset = 1'b0;
    nextCycle();

    $display("[TB] write/read round trip");
    auto_en   = 1'b1;
    ack_delay = 1;
    applyStimulus(1'b1, 5'd5, 32'hC0A8_0001, 1'b0, t);
    expectRsp(1'b0, 32'h0, t + 3);
    waitNeg(t + 1);
    checkOutput("wr_req_pulse", 64'(tbl_wr_req),  64'd1);
    checkOutput("wr_rd_req",    64'(tbl_rd_req),  64'd0);
    checkOutput("wr_addr",      64'(tbl_wr_addr), 64'd5);
    checkOutput("wr_data",      64'(tbl_wr_data), 64'hC0A8_0001);
    checkOutput("wr_cmd_ready", 64'(cmd_ready),   64'd0);
    checkOutput("wr_busy",      64'(busy),        64'd1);
    waitNeg(t + 2);
    checkOutput("wr_req_drop",  64'(tbl_wr_req),  64'd0);
    drainScoreboard(10);
    nextCycle();
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b0, t);
    expectRsp(1'b0, 32'hC0A8_0001, t + 3);
    waitNeg(t + 1);
    checkOutput("rd_req_pulse", 64'(tbl_rd_req),  64'd1);
    checkOutput("rd_addr",      64'(tbl_rd_addr), 64'd5);
    drainScoreboard(10);

    $display("[TB] timeout with silent responder");
    auto_en = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 5'd3, 32'h0, 1'b0, t);
    expectRsp(1'b1, 32'h0, t + 2 + TO);
    waitNeg(t + 1 + TO);
    checkOutput("to_ready_low",  64'(cmd_ready),     64'd0);
    waitNeg(t + 2 + TO);
    checkOutput("to_count",      64'(timeout_count), 64'd1);
    checkOutput("to_ready_back", 64'(cmd_ready),     64'd1);
    waitNeg(t + 3 + TO);
    checkOutput("to_rsp_width",  64'(rsp_valid),     64'd0);
    drainScoreboard(5);

    $display("[TB] ack in the last wait cycle");
    auto_en   = 1'b1;
    ack_delay = TO;
    nextCycle();
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b0, t);
    expectRsp(1'b0, 32'hC0A8_0001, t + 2 + TO);
    drainScoreboard(30);
    checkOutput("edge_count", 64'(timeout_count), 64'd1);

    $display("[TB] wrong ack type");
    auto_en   = 1'b0;
    ack_delay = 1;
    nextCycle();
    base_rsp = rsp_pulses;
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 1'b0, t);
    sched_rd = t + 3;
    sched_wr = t + 6;
    expectRsp(1'b0, 32'hC0A8_0001, t + 7);
    waitNeg(t + 10);
    drainScoreboard(5);
    checkOutput("wrong_ack_rsps", 64'(rsp_pulses - base_rsp), 64'd1);

    $display("[TB] acks while idle");
    nextCycle();
    base_rsp = rsp_pulses;
    sched_rd = cycle + 2;
    sched_wr = cycle + 3;
    repeat (6) nextCycle();
    @(negedge AXI_ACLK);
    checkOutput("idle_ack_rsps", 64'(rsp_pulses - base_rsp), 64'd0);
    checkOutput("idle_ack_busy", 64'(busy), 64'd0);
    sched_rd = -1;
    sched_wr = -1;

    $display("[TB] back-to-back writes");
    auto_en   = 1'b1;
    ack_delay = 1;
    nextCycle();
    base_req = req_pulses;
    base_rsp = rsp_pulses;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, AW'(i), 32'hA0 + 32'(i), 1'b1, tb2b[i]);
      expectRsp(1'b0, 32'hC0A8_0001, tb2b[i] + 3);
    end
    cmd_valid = 1'b0;
    drainScoreboard(10);
    for (int i = 1; i < 4; i++) checkOutput("b2b_accept_gap", 64'(tb2b[i] - tb2b[0]), 64'(3 * i));
    checkOutput("b2b_req_pulses", 64'(req_pulses - base_req), 64'd4);
    checkOutput("b2b_rsp_pulses", 64'(rsp_pulses - base_rsp), 64'd4);

    $display("[TB] reset during wait");
    auto_en = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 5'd9, 32'h0, 1'b0, t);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    @(negedge AXI_ACLK);
    checkResetState("wait_rst");
    base_rsp = rsp_pulses;
    repeat (TO + 6) nextCycle();
    @(negedge AXI_ACLK);
    checkOutput("abandoned_rsps", 64'(rsp_pulses - base_rsp), 64'd0);
    auto_en = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 5'd5, 32'h0, 1'b0, t);
    expectRsp(1'b0, 32'hC0A8_0001, t + 3);
    drainScoreboard(10);

    $display("[TB] clear racing a timeout");
    auto_en = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 5'd2, 32'h0, 1'b0, t);
    expectRsp(1'b1, 32'h0, t + 2 + TO);
    drainScoreboard(30);
    checkOutput("clr_pre_count", 64'(timeout_count), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 5'd4, 32'h0, 1'b0, t2);
    expectRsp(1'b1, 32'h0, t2 + 2 + TO);
    while (cycle < t2 + 1 + TO) nextCycle();
    cnt_clear = 1'b1;
    nextCycle();
    cnt_clear = 1'b0;
    @(negedge AXI_ACLK);
    checkOutput("clr_vs_timeout", 64'(timeout_count), 64'd0);
    drainScoreboard(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tbl_access_master.md
# tbl_access_master

Initiator side of the forwarding-table access handshake (`tbl_*_req` / `tbl_*_ack`) used by the output-port-lookup table blocks.
- Converts single software table commands from the register block into one-cycle read or write request pulses.
- Waits for the matching acknowledge, captures read data, and returns one response per command.
- Guards against a silent or absent table with a cycle timeout and an error counter.

## Interface
Parameters:
- C_S_AXI_DATA_WIDTH, 32, table entry / data width
- TBL_ADDR_WIDTH, 5, table index width (32 entries)
- TIMEOUT_CYCLES, 16, WAIT cycles without a matching ack before error; legal range 2..255

Ports (reset reset, synchronous, active-high; clock AXI_ACLK):
- AXI_ACLK  in  1  clock
- reset  in  1  synchronous active-high reset
- cmd_valid  in  1  software command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  TBL_ADDR_WIDTH  table index
- cmd_wdata  in  C_S_AXI_DATA_WIDTH  write value
- rsp_valid  out  1  one-cycle response pulse
- rsp_error  out  1  qualifies rsp_valid: timeout occurred
- rsp_rdata  out  C_S_AXI_DATA_WIDTH  read result; held until next response
- busy  out  1  state != IDLE
- timeout_count  out  32  saturating count of timed-out commands
- cnt_clear  in  1  zeroes timeout_count
- tbl_rd_req  out  1  read request pulse
- tbl_wr_req  out  1  write request pulse
- tbl_rd_addr  out  TBL_ADDR_WIDTH  read index
- tbl_wr_addr  out  TBL_ADDR_WIDTH  write index
- tbl_wr_data  out  C_S_AXI_DATA_WIDTH  write value
- tbl_rd_data  in  C_S_AXI_DATA_WIDTH  read value, valid with tbl_rd_ack
- tbl_rd_ack  in  1  read acknowledge
- tbl_wr_ack  in  1  write acknowledge

## Operation
- FSM states: IDLE, ISSUE, WAIT. All outputs are registered.
- IDLE: cmd_ready = 1.
  - On accept, latch cmd_write into an op flag.
  - Read: load tbl_rd_addr <= cmd_addr.
  - Write: load tbl_wr_addr <= cmd_addr and tbl_wr_data <= cmd_wdata.
  - Go to ISSUE.
- ISSUE: exactly one cycle.
  - tbl_wr_req = 1 for a write, tbl_rd_req = 1 for a read; the other req stays 0.
  - Clear the timeout counter (8 bits). Go to WAIT.
- WAIT: both req = 0.
  - Matching ack (tbl_wr_ack for a write, tbl_rd_ack for a read) -> IDLE with rsp_valid = 1 and rsp_error = 0 on the next cycle.
  - For a read, also rsp_rdata <= tbl_rd_data, sampled in the ack cycle.
  - For a write, rsp_rdata is unchanged.
  - Non-matching ack is ignored.
  - No matching ack and counter == TIMEOUT_CYCLES-1 -> IDLE with rsp_valid = 1, rsp_error = 1, rsp_rdata <= 0; timeout_count increments, saturating at 32'hFFFFFFFF.
  - Otherwise the counter increments.
- Matching ack and timeout in the same cycle: ack wins, no error.
- Acks arriving in IDLE or ISSUE are ignored and never produce a response.
- tbl_*_addr and tbl_wr_data hold their last loaded values until the next accept.
- cnt_clear has priority over a simultaneous timeout increment; the result is 0.
- Reset values: state IDLE; cmd_ready 1; rsp_valid, rsp_error, busy, tbl_rd_req, tbl_wr_req 0; rsp_rdata, timeout_count, addresses, tbl_wr_data 0.
- Reset asserted in ISSUE or WAIT:
  - Abandons the command; no response is generated.
  - Any req drops at the same edge.

## Timing
- Command accepted at cycle T: req high in T+1 only; WAIT from T+2.
- With an ack one cycle after req (ack in T+2): rsp_valid in T+3, and cmd_ready = 1 in T+3. The next command can be accepted in T+3, giving a 3-cycle throughput per command.
- Ack in WAIT cycle k (k = 0 at T+2): rsp_valid at T+3+k.
- No ack: last WAIT cycle is T+1+TIMEOUT_CYCLES; error response in T+2+TIMEOUT_CYCLES (T+18 at the default).
- rsp_valid is high for exactly one cycle; no backpressure on responses.
- cmd_ready is 0 from T+1 until the response cycle.

## Test plan
- Write/read round trip with a model table (ack 1 cycle after req): write addr 5 = 0xC0A80001, then read addr 5. Required:
  - tbl_wr_req pulses one cycle at T+1 with tbl_wr_addr = 5.
  - Read response at T+3 with rsp_rdata = 0xC0A80001 and rsp_error = 0.
- Timeout, responder silent, read addr 3 accepted at T: rsp_valid and rsp_error = 1 at T+18, rsp_rdata = 0, timeout_count = 1; cmd_ready returns to 1 at T+18.
- Boundary: responder acks at T+17. Required: rsp_error = 0, data captured, timeout_count unchanged.
- Wrong ack type: tbl_rd_ack asserted during a write's WAIT, tbl_wr_ack 3 cycles later. Required: only one response, at the wr_ack cycle + 1.
- Back-to-back: 4 writes to addrs 0..3 with cmd_valid held high. Required:
  - Accepts at T, T+3, T+6, T+9.
  - Exactly 4 req pulses and 4 rsp_valid pulses.
- Reset in WAIT: assert reset at T+2 for 1 cycle, then send a read. Required:
  - No response for the abandoned command.
  - All outputs at reset values.
  - The new read completes normally.
  - cnt_clear together with a timeout yields timeout_count = 0.
